// File: rtl/seq_delay_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency delay pipeline.
// Each word carries its source tag and returns on that requester's strobe.
module seq_delay_arbiter #(
    parameter int WIDTH   = 2,
    parameter int DEPTH   = 4,
    parameter int NREQ    = 3,
    parameter int MAX_OUT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  flush,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy
);
    localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
    localparam logic [TW-1:0] LAST_REQ = TW'(NREQ - 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [TW-1:0]    tag_q  [DEPTH];
    logic [TW-1:0]    tag_d  [DEPTH];
    logic [CW-1:0]    cnt_q  [NREQ];
    logic [CW-1:0]    cnt_d  [NREQ];
    logic [TW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             busy_q, busy_d;

    logic [NREQ-1:0]  elig;
    logic             gnt_any;
    logic [TW-1:0]    gnt_idx;
    logic [TW-1:0]    idx;
    logic             inc, dec;

    always_comb begin
        elig    = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && (cnt_q[i] < MAX_C) && !flush && !reset;
        end
        // First eligible requester at or after ptr, wrapping
        for (int k = 0; k < NREQ; k++) begin
            idx = TW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_any && elig[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        inc = 1'b0;
        dec = 1'b0;
        valid_d[0] = gnt_any;
        data_d[0]  = gnt_any ? req_data[gnt_idx*WIDTH +: WIDTH] : '0;
        tag_d[0]   = gnt_any ? gnt_idx : '0;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            data_d[k]  = data_q[k-1];
            tag_d[k]   = tag_q[k-1];
        end
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + TW'(1);
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            inc = gnt_any && (gnt_idx == TW'(i));
            dec = valid_q[DEPTH-1] && (tag_q[DEPTH-1] == TW'(i));
            if (inc && !dec) cnt_d[i] = cnt_q[i] + CW'(1);
            else if (dec && !inc) cnt_d[i] = cnt_q[i] - CW'(1);
        end
        if (flush) begin
            valid_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_d[k] = '0;
                tag_d[k]  = '0;
            end
            for (int i = 0; i < NREQ; i++) cnt_d[i] = '0;
        end
        // Output registers mirror what the last stage is about to hold
        rsp_valid_d = valid_d[DEPTH-1] ? (NREQ'(1) << tag_d[DEPTH-1]) : '0;
        rsp_data_d  = data_d[DEPTH-1];
        busy_d      = |valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            valid_q     <= valid_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
                tag_q[k]  <= tag_d[k];
            end
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
endmodule

// File: doc/seq_delay_arbiter.md
# seq_delay_arbiter

Round-robin arbiter that shares one DEPTH-stage, WIDTH-bit synchronous-reset delay pipeline among NREQ requesters. Each accepted word travels the pipeline with a valid bit and a source tag, and is returned on a per-requester response strobe exactly DEPTH cycles later. Per-requester credit counters cap words in flight, and a flush command clears the pipeline. The block sits between the fixture's sequential delay lines and the multiple agents that time-share them.

## Interface
- WIDTH, 2, data width of each pipeline stage
- DEPTH, 4, pipeline stages; legal range ≥1
- NREQ, 3, number of requesters; legal range ≥2
- MAX_OUT, 2, maximum words in flight per requester; legal range ≥1
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request
- req_data  in  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot grant; combinational, may depend on req_valid
- flush  in  1  synchronous pipeline clear
- rsp_valid  out  NREQ  one-hot response strobe, registered
- rsp_data  out  WIDTH  response word, registered
- busy  out  1  high while any stage holds a valid word, registered

## Operation
- Per stage: valid bit, data[WIDTH], tag[clog2(NREQ)]. The pipeline advances every cycle with no stall and no output backpressure.
- Stage 0 loads the granted word (valid=1, tag=i), or a bubble (valid=0, data=0, tag=0) when there is no grant.
- Stage k loads stage k-1.
- rsp_valid[tag of last stage] = last-stage valid. rsp_data = last-stage data. A bubble gives rsp_data = 0.
- Eligibility of requester i: req_valid[i] & (outstanding[i] < MAX_OUT) & !flush & !reset.
- Arbitration is round robin:
  - Search starts at ptr and wraps modulo NREQ; the first eligible requester is granted.
  - At most one grant per cycle.
  - On a grant to i, ptr ← (i+1) mod NREQ. With no grant, ptr holds.
- outstanding[i] counters, width clog2(MAX_OUT+1):
  - +1 on grant to i; −1 when the last stage retires tag i with valid=1.
  - Grant and retire in the same cycle leave the count unchanged.
  - The credit check uses the registered count. A retirement in the current cycle does not free a credit until the next cycle.
- flush (registered effect at the edge):
  - All stage valid, data and tag clear to 0 and all counters clear to 0.
  - No grant is issued in the flush cycle (req_ready = 0).
  - A word sitting in the last stage during the flush cycle is still presented on rsp_valid/rsp_data in that cycle, since the outputs are registered. It is dropped from the counters because they clear.
- busy = OR of all stage valid bits.

## Timing
- Reset values: all stages valid=0, data=0, tag=0; ptr=0; counters 0; rsp_valid=0; rsp_data=0; busy=0. req_ready=0 while reset is high.
- Latency: a word accepted in cycle c (req_valid & req_ready high) appears on rsp_valid/rsp_data in cycle c+DEPTH, high for exactly one cycle.
- DEPTH=1: response in the cycle following acceptance.
- Throughput: one word per cycle aggregate. Per requester, at most MAX_OUT words in flight.
- Credit limit:
  - With MAX_OUT < DEPTH, a lone requester stalls after MAX_OUT grants until its first response cycle.
  - It is regranted in the cycle after that response.
- Reset or flush mid-operation: all in-flight words are discarded. No rsp_valid follows for them after the clearing edge.
- req_valid dropped without a grant: no state change and ptr holds.

## Test plan
- Single word (DEPTH=4): reset, then req_valid[1]=1, data=2'b10 in cycle 5 → req_ready[1]=1 in cycle 5; rsp_valid=3'b010, rsp_data=2'b10 in cycle 9 only; busy high in cycles 6–9.
- Round robin: requesters 0,1,2 valid continuously from cycle 0 with data 1,2,3 → grants 0,1,2,0,1,2…; after grant 2 the next grant is 0 (pointer wrap). Responses appear in the same order starting DEPTH cycles later.
- Credit stall (MAX_OUT=2, DEPTH=4): only requester 0 valid from cycle 0 → grants in cycles 0,1; req_ready[0]=0 in cycles 2–4; responses in cycles 4,5; regrant in cycle 5.
- Flush: fill the pipeline with 3 words, assert flush one cycle → req_ready=0 that cycle; no rsp_valid afterward for the flushed words; busy=0 and counters 0 the next cycle; a new request is accepted immediately.
- Mid-operation reset: 2 words in flight, reset high one cycle → all outputs at reset values the next cycle; no stale response ever appears; ptr restarts at requester 0.
- Bubbles: alternate req_valid on requester 2 with data 2'b11 → rsp_data=0 in every cycle where rsp_valid=0.
